ips_dbc_capture_buffer_v1_2: RTL
================================

// Module: ips_dbc_capture_buffer_v1_2
// PURPOSE
//  Single-clock trace buffer for the debug core. It stores qualified samples
//  into a circular RAM with a runtime pre-trigger depth, then stops after the
//  post-trigger window. Readout is relative to the oldest stored sample.
//  Sits between the trigger unit and the JTAG readout/register block.
// PARAMETERS
//  MEM_STYLE   0  0=block RAM inference, 1=distributed/LUT RAM
//  ADDR_WIDTH  9  buffer depth DEPTH = 2**ADDR_WIDTH samples
//  DATA_WIDTH  8  sample width
// PORTS
//  clk        in   1           single clock
//  rst        in   1           asynchronous reset, active-high
//  arm        in   1           pulse: start (or restart) a capture
//  abort      in   1           pulse: cancel capture, return to IDLE
//  trig_pos   in   ADDR_WIDTH  pre-trigger sample count, sampled on arm
//  smp_en     in   1           storage qualifier; sample written only when 1
//  trig_in    in   1           trigger; honoured only when smp_en=1
//  din        in   DATA_WIDTH  sample data
//  busy       out  1           state is PRE, ARMED or POST
//  triggered  out  1           trigger accepted in the current capture
//  done       out  1           capture complete, buffer readable
//  trig_addr  out  ADDR_WIDTH  physical RAM address of the trigger sample
//  rd_en      in   1           read request
//  rd_addr    in   ADDR_WIDTH  read index; 0 = oldest sample
//  q          out  DATA_WIDTH  read data, registered, held between reads
//  q_valid    out  1           1-cycle pulse: q updated
// BEHAVIOUR
//  - Reset: IDLE; busy/triggered/done/q_valid=0; trig_addr=0; q=0; wr_ptr=0.
//    RAM contents are not reset.
//  - States:
//    - IDLE -arm-> PRE (trig_pos!=0) or ARMED (trig_pos=0).
//    - PRE: write; pre_cnt++. When pre_cnt reaches trig_pos -> ARMED.
//      trig_in is ignored in PRE.
//    - ARMED: write on every smp_en. smp_en & trig_in -> POST.
//      That sample is the trigger sample: trig_addr=wr_ptr, triggered=1,
//      post_cnt=1.
//    - POST: write; post_cnt++. The write making post_cnt = DEPTH-trig_pos
//      -> DONE (trig_pos=0 gives DEPTH post samples). done=1 next cycle.
//    - DONE: no writes; holds until arm or abort.
//  - Write: RAM[wr_ptr]<=din on the edge where smp_en=1 in PRE/ARMED/POST.
//    wr_ptr increments mod DEPTH and wraps freely.
//  - arm in any state restarts the capture: counters and flags clear,
//    wr_ptr kept. abort -> IDLE, flags clear. abort wins over a
//    simultaneous arm.
//  - arm, trig_in and smp_en all 1 in the same cycle: no write; the
//    trigger is not taken.
//  - Readout: only in DONE. phys = (trig_addr - trig_pos_l + rd_addr)
//    mod DEPTH. q and q_valid follow rd_en by 1 clock.
//    rd_en outside DONE: ignored, q_valid=0, q held.
//  - Read/write collision cannot occur, since reads happen only in DONE.
//  - All address arithmetic is ADDR_WIDTH-bit unsigned modulo DEPTH.
//  - rst mid-capture: immediate IDLE with reset values.
// STRUCTURE
//  - Shared package ips_dbc_pkg: state encoding localparams
//    (IDLE, PRE, ARMED, POST, DONE) and MEM_STYLE codes.
//  - Sub-module ips_dbc_capture_ram_v1_2: simple dual-port RAM, write port
//    plus registered read port, MEM_STYLE-selected.
//  - This block holds the FSM, counters, pointers and address translation.
// TESTING (ADDR_WIDTH=4, DEPTH=16, DATA_WIDTH=8, din = sample index 0,1,..)
//  1. trig_pos=4, smp_en=1, trig at din=10 -> done after din=21.
//     Reads 0..15 -> 6..21; trig_addr=10.
//  2. trig_pos=4, trig_in high at din=1 (PRE) -> ignored.
//     trig at din=7 -> reads 0..15 -> 3..18.
//  3. smp_en alternating 1/0, trig_pos=0 -> only qualified samples stored.
//     done after 16 qualified samples; reads return consecutive values.
//  4. trig_pos=4, trigger after 100 samples (wrap) -> read 0 = trig-4,
//     read 4 = trig, correct across the wrap.
//  5. abort in POST -> IDLE, done=0. arm+abort same cycle -> IDLE.
//     rd_en while busy -> q_valid=0.
//  6. rst asserted in POST -> all outputs 0 at once. Rearm -> capture OK.

Source files
------------

// File: rtl/ips_dbc_pkg.sv
// Shared definitions for the debug-core capture buffer: the capture FSM
// state encoding and the RAM implementation style codes.
package ips_dbc_pkg;

    // Capture FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // RAM implementation style selectors
    localparam int MEM_STYLE_BLOCK = 0;
    localparam int MEM_STYLE_DIST  = 1;

endpackage : ips_dbc_pkg

// File: rtl/ips_dbc_capture_ram_v1_2.sv
// Simple dual-port sample RAM: one write port and one registered read port.
// The read register holds its value between reads. MEM_STYLE steers the
// synthesis tool towards block or distributed memory.
module ips_dbc_capture_ram_v1_2
    import ips_dbc_pkg::*;
#(
    parameter int MEM_STYLE  = MEM_STYLE_BLOCK,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    generate
        if (MEM_STYLE == MEM_STYLE_DIST) begin : g_dist
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            // Sample write port
            // NOTE: the array has no reset so it maps onto real RAM primitives;
            // only the read register below is reset.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end

            // Next read data: new word on a read, otherwise hold
            // NOTE: assigning the default (hold) first on every path keeps this
            // purely combinational and prevents an inferred latch.
            always_comb begin
                rdata_d = rdata_q;
                if (re) begin
                    rdata_d = mem[raddr];
                end
            end
        end else begin : g_block
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            // Sample write port
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end

            // Next read data: new word on a read, otherwise hold
            always_comb begin
                rdata_d = rdata_q;
                if (re) begin
                    rdata_d = mem[raddr];
                end
            end
        end
    endgenerate

    // Registered read port
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule : ips_dbc_capture_ram_v1_2

// File: rtl/ips_dbc_capture_buffer_v1_2.sv
// Debug-core trace buffer. Stores qualified samples into a circular RAM,
// keeps a runtime-selected number of pre-trigger samples, stops once the
// post-trigger window is full, and reads back relative to the oldest sample.
module ips_dbc_capture_buffer_v1_2
    import ips_dbc_pkg::*;
#(
    parameter int MEM_STYLE  = MEM_STYLE_BLOCK,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] trig_pos,
    input  logic                  smp_en,
    input  logic                  trig_in,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid
);

    // Post counter is one bit wider so trig_pos=0 can count a full DEPTH.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ONE_P   = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_WIDTH:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_WIDTH-1:0] trig_pos_l_q, trig_pos_l_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  triggered_q, triggered_d;
    logic                  q_valid_q, q_valid_d;

    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [ADDR_WIDTH:0]   post_target;

    // Number of post-trigger samples (trigger sample included) for this capture
    assign post_target = DEPTH_W - {1'b0, trig_pos_l_q};

    // Capture FSM next-state, counters, pointers and write strobe
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        trig_pos_l_d = trig_pos_l_q;
        trig_addr_d  = trig_addr_q;
        wr_ptr_d     = wr_ptr_q;
        triggered_d  = triggered_q;
        ram_we       = 1'b0;

        if (abort) begin
            // Abort dominates a simultaneous arm.
            state_d     = ST_IDLE;
            pre_cnt_d   = '0;
            post_cnt_d  = '0;
            triggered_d = 1'b0;
        end else if (arm) begin
            // Restart from any state; wr_ptr keeps running. The arm cycle
            // never writes and never accepts a trigger.
            trig_pos_l_d = trig_pos;
            pre_cnt_d    = '0;
            post_cnt_d   = '0;
            triggered_d  = 1'b0;
            state_d      = (trig_pos != '0) ? ST_PRE : ST_ARMED;
        end else begin
            unique case (state_q)
                ST_PRE: begin
                    // Fill the pre-trigger window; triggers are ignored here.
                    if (smp_en) begin
                        ram_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_q + ONE_A;
                        pre_cnt_d = pre_cnt_q + ONE_A;
                        if (pre_cnt_d == trig_pos_l_q) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (smp_en) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_A;
                        if (trig_in) begin
                            trig_addr_d = wr_ptr_q;
                            triggered_d = 1'b1;
                            post_cnt_d  = ONE_P;
                            state_d     = (post_target == ONE_P) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (smp_en) begin
                        ram_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + ONE_A;
                        post_cnt_d = post_cnt_q + ONE_P;
                        if (post_cnt_d == post_target) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE: no writes, wait for arm/abort.
                end
            endcase
        end
    end

    // Readout translation: index 0 is the oldest stored sample
    always_comb begin
        ram_re    = rd_en && (state_q == ST_DONE);
        ram_raddr = trig_addr_q - trig_pos_l_q + rd_addr;
        q_valid_d = ram_re;
    end

    // Control and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            trig_pos_l_q <= '0;
            trig_addr_q  <= '0;
            wr_ptr_q     <= '0;
            triggered_q  <= 1'b0;
            q_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            trig_pos_l_q <= trig_pos_l_d;
            trig_addr_q  <= trig_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            triggered_q  <= triggered_d;
            q_valid_q    <= q_valid_d;
        end
    end

    ips_dbc_capture_ram_v1_2 #(
        .MEM_STYLE  (MEM_STYLE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (q)
    );

    assign busy      = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign done      = (state_q == ST_DONE);
    assign triggered = triggered_q;
    assign trig_addr = trig_addr_q;
    assign q_valid   = q_valid_q;

endmodule : ips_dbc_capture_buffer_v1_2
